clk_gate_ctrl: RTL
==================

Name: clk_gate_ctrl

Overview:
- Idle-detection clock-gating controller; the stage directly upstream of the clock-gate cell wrapper.
- Its registered clk_en_o drives the wrapper's en_i.
- Monitors unit activity and incoming requests; gates the unit clock after a programmable idle period.
- Reopens the clock and stalls the request handshake until the woken clock domain has settled.
- Runs on the ungated clock.

Parameters:
- IDLE_CNT_W, 8, width of idle threshold and idle counter.
- WAKE_LATENCY, 2, cycles clk_en_o is held high in WAKE before requests are accepted (legal 1..15).
- STATS_W, 32, width of gated-cycle statistics counter (optional feature only).

Ports:
- clk_i  in  1  free-running (ungated) clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_en_i  in  1  auto-gating enable; 0 forces clock on.
- idle_thresh_i  in  IDLE_CNT_W  consecutive idle cycles required before gating; 0 treated as 1.
- busy_i  in  1  gated unit has in-flight work.
- wake_i  in  1  explicit wake request (synchronous to clk_i).
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  upstream request ready.
- ready_i  in  1  ready from gated unit.
- clk_en_o  out  1  clock enable to gate cell; registered.
- gated_o  out  1  1 while in GATED.
- gated_cycles_o  out  STATS_W  saturating count of gated cycles.

Behaviour:
- Reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: state RUN, clk_en_o=1, gated_o=0, idle counter 0, wake counter 0, gated_cycles_o=0.
- Activity: act = busy_i | req_valid_i | wake_i. thr = (idle_thresh_i==0) ? 1 : idle_thresh_i.
- RUN:
  - clk_en_o=1.
  - If cfg_en_i & ~act: go to COUNT with idle counter=1.
- COUNT:
  - clk_en_o=1.
  - If act | ~cfg_en_i: go to RUN, counter cleared.
  - Else if counter==thr: go to GATED; clk_en_o goes 0 on that same edge.
  - Else counter+1.
  - Counter never wraps; it stops at thr.
- GATED:
  - clk_en_o=0, gated_o=1.
  - If act | ~cfg_en_i: go to WAKE; clk_en_o=1 registered on that edge; wake counter=1.
- WAKE:
  - clk_en_o=1.
  - Wake counter increments each cycle; when counter==WAKE_LATENCY, go to RUN.
  - Inputs are ignored in WAKE; the state always completes.
- Latency:
  - thr consecutive idle cycles in COUNT, plus the RUN→COUNT cycle, before clk_en_o falls.
  - Wake: clk_en_o rises 1 cycle after act is sampled in GATED.
  - req_ready_o rises WAKE_LATENCY+1 cycles after that.
- Handshake:
  - req_ready_o = ready_i & (state==RUN | state==COUNT); combinational from state register and ready_i.
  - A request is transferred when req_valid_i & req_ready_o.
  - req_valid_i is held by upstream while ready is low; the controller never drops a request.
- clk_en_o:
  - Driven only from a flop; no combinational path from inputs.
  - Changes only on rising clk_i, so the cell latch sees a stable enable during the high phase.
- Simultaneous events:
  - act asserted on the cycle counter reaches thr: act wins, go to RUN, no gating.
  - cfg_en_i falling in any state other than WAKE forces RUN (via WAKE if gated).
- Asynchronous reset mid-GATED: clk_en_o returns to 1 immediately; state RUN.

Optional Feature:
- Macro: CLK_GATE_CTRL_STATS_EN.
- Defined:
  - gated_cycles_o increments by 1 every cycle state==GATED.
  - Saturates at all-ones; cleared only by reset.
- Undefined:
  - Counter logic omitted; gated_cycles_o tied to 0.
  - All other behaviour identical.

Test Plan:
- Reset, cfg_en_i=1, idle_thresh_i=4, all activity 0 → clk_en_o=1 at reset release; falls to 0 on the 5th edge after release; gated_o=1.
- GATED, pulse req_valid_i=1 held, ready_i=1, WAKE_LATENCY=2 → clk_en_o=1 next cycle; req_ready_o=1 three cycles after req_valid_i sampled; exactly one transfer.
- idle_thresh_i=4, busy_i pulses for one cycle at idle count 3 → return to RUN, counter restarts, gating occurs only after 4 further idle cycles.
- idle_thresh_i=0 → gating after 1 idle count cycle (same as thr=1).
- In GATED, drop cfg_en_i → WAKE then RUN; clk_en_o stays 1 while cfg_en_i=0 despite idle inputs.
- With CLK_GATE_CTRL_STATS_EN, STATS_W=4, hold GATED 20 cycles → gated_cycles_o=15 (saturated); assert rst_ni=0 mid-GATED → clk_en_o=1 and gated_cycles_o=0 asynchronously.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Idle-detection clock-gating controller driving the gate-cell wrapper enable.
// Optional gated-cycle statistics counter enabled by defining CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl #(
  parameter int IDLE_CNT_W   = 8,
  parameter int WAKE_LATENCY = 2,
  parameter int STATS_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_en_i,
  input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
  input  logic                  busy_i,
  input  logic                  wake_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  ready_i,
  output logic                  clk_en_o,
  output logic                  gated_o,
  output logic [STATS_W-1:0]    gated_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_COUNT = 2'b01,
    ST_GATED = 2'b10,
    ST_WAKE  = 2'b11
  } state_t;

  localparam logic [3:0] WAKE_LAT_C = 4'(WAKE_LATENCY);

  state_t                  state_r, state_nxt_s;
  logic [IDLE_CNT_W-1:0]   idle_cnt_r, idle_cnt_nxt_s;
  logic [3:0]              wake_cnt_r, wake_cnt_nxt_s;
  logic [IDLE_CNT_W-1:0]   thr_s;
  logic                    act_s;
  logic                    clk_en_r, gated_r;

  assign act_s = busy_i | req_valid_i | wake_i;

  // A zero threshold behaves as a threshold of one.
  always_comb begin
    thr_s = idle_thresh_i;
    if (idle_thresh_i == {IDLE_CNT_W{1'b0}}) begin
      thr_s = IDLE_CNT_W'(1'b1);
    end else begin
      thr_s = idle_thresh_i;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_nxt_s    = state_r;
    idle_cnt_nxt_s = idle_cnt_r;
    wake_cnt_nxt_s = wake_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (cfg_en_i && !act_s) begin
          state_nxt_s    = ST_COUNT;
          idle_cnt_nxt_s = IDLE_CNT_W'(1'b1);
        end else begin
          idle_cnt_nxt_s = {IDLE_CNT_W{1'b0}};
        end
      end
      ST_COUNT: begin
        // Activity wins over reaching the threshold on the same cycle.
        if (act_s || !cfg_en_i) begin
          state_nxt_s    = ST_RUN;
          idle_cnt_nxt_s = {IDLE_CNT_W{1'b0}};
        end else if (idle_cnt_r >= thr_s) begin
          state_nxt_s    = ST_GATED;
        end else begin
          idle_cnt_nxt_s = idle_cnt_r + IDLE_CNT_W'(1'b1);
        end
      end
      ST_GATED: begin
        if (act_s || !cfg_en_i) begin
          state_nxt_s    = ST_WAKE;
          idle_cnt_nxt_s = {IDLE_CNT_W{1'b0}};
          wake_cnt_nxt_s = 4'd1;
        end else begin
          state_nxt_s    = ST_GATED;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_r >= WAKE_LAT_C) begin
          state_nxt_s    = ST_RUN;
          wake_cnt_nxt_s = 4'd0;
        end else begin
          wake_cnt_nxt_s = wake_cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s    = ST_RUN;
        idle_cnt_nxt_s = {IDLE_CNT_W{1'b0}};
        wake_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // State, counters and registered enable; enable depends only on next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_RUN;
      idle_cnt_r <= {IDLE_CNT_W{1'b0}};
      wake_cnt_r <= 4'd0;
      clk_en_r   <= 1'b1;
      gated_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      wake_cnt_r <= wake_cnt_nxt_s;
      clk_en_r   <= (state_nxt_s != ST_GATED);
      gated_r    <= (state_nxt_s == ST_GATED);
    end
  end

  assign clk_en_o    = clk_en_r;
  assign gated_o     = gated_r;
  assign req_ready_o = ready_i & ((state_r == ST_RUN) | (state_r == ST_COUNT));

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [STATS_W-1:0] gated_cycles_r;

  // Saturating count of cycles spent gated.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gated_cycles_r <= {STATS_W{1'b0}};
    end else if ((state_r == ST_GATED) && (gated_cycles_r != {STATS_W{1'b1}})) begin
      gated_cycles_r <= gated_cycles_r + STATS_W'(1'b1);
    end else begin
      gated_cycles_r <= gated_cycles_r;
    end
  end

  assign gated_cycles_o = gated_cycles_r;
`else
  assign gated_cycles_o = {STATS_W{1'b0}};
`endif

endmodule
